// File: rtl/evt_window_scheduler_pkg.sv
// Shared types and widths for the DVS event window scheduler.
// Holds the scheduler state encoding and a saturating counter helper.
package dlgn_evt_pkg;

    localparam int TS_W    = 34;
    localparam int COORD_W = 14;
    localparam int CNT_W   = 16;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ACCUM = 3'd2,
        ST_START = 3'd3,
        ST_WAIT  = 3'd4
    } evt_sched_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/evt_window_scheduler_if.sv
// Camera event stream into the window scheduler.
// master = event source, slave = scheduler.
interface evt_window_scheduler_if;
    import dlgn_evt_pkg::*;

    // Valid/ready: an event transfers on every cycle where evt_valid_i and
    // evt_ready_o are both high. The source keeps valid and payload stable
    // until that cycle; ready may depend on the payload (timestamp).
    logic [TS_W-1:0]    evt_timestamp_i;
    logic [COORD_W-1:0] evt_x_i;
    logic [COORD_W-1:0] evt_y_i;
    logic               evt_polarity_i;
    logic               evt_valid_i;
    logic               evt_ready_o;

    modport master (
        output evt_timestamp_i,
        output evt_x_i,
        output evt_y_i,
        output evt_polarity_i,
        output evt_valid_i,
        input  evt_ready_o
    );

    modport slave (
        input  evt_timestamp_i,
        input  evt_x_i,
        input  evt_y_i,
        input  evt_polarity_i,
        input  evt_valid_i,
        output evt_ready_o
    );

endinterface

// File: rtl/evt_window_scheduler_sweeper.sv
// Frame accumulator clear sweep: one word per cycle from address 0 to FRAME_WORDS-1.
// start_i is honoured only while idle; done_o marks the last swept word.
module frame_clear_sweeper #(
    parameter int FRAME_WORDS = 1156,
    parameter int AW          = 11
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_addr_o
);

    logic          busy_q;
    logic [AW-1:0] addr_q;
    logic          last_word;

    assign last_word  = (addr_q == AW'(FRAME_WORDS - 1));
    assign busy_o     = busy_q;
    assign done_o     = busy_q && last_word;
    assign clr_we_o   = busy_q;
    assign clr_addr_o = addr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_q <= 1'b0;
            addr_q <= '0;
        end else if (busy_q) begin
            if (last_word) begin
                busy_q <= 1'b0;
                addr_q <= '0;
            end else begin
                addr_q <= addr_q + 1'b1;
            end
        end else if (start_i) begin
            busy_q <= 1'b1;
            addr_q <= '0;
        end
    end

endmodule

// File: rtl/evt_window_scheduler.sv
// Gates DVS events into the frame accumulator in fixed timestamp windows and
// sequences inference/clear between windows. Optional stats: EVT_SCHED_STATS_EN.
module evt_window_scheduler
    import dlgn_evt_pkg::*;
#(
    parameter int WIDTH         = 34,
    parameter int HEIGHT        = 34,
    parameter int WINDOW_LEN    = 10000,
    parameter int MIN_EVENTS    = 16,
    parameter int FRAME_WORDS   = 1156,
    parameter int INFER_TIMEOUT = 4096,
    localparam int AXW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int AYW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
    localparam int CAW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1,
    localparam int TW  = $clog2(INFER_TIMEOUT + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    evt_window_scheduler_if.slave evt,
    output logic                 acc_we_o,
    output logic [AXW-1:0]       acc_x_o,
    output logic [AYW-1:0]       acc_y_o,
    output logic                 acc_pol_o,
    output logic                 clr_we_o,
    output logic [CAW-1:0]       clr_addr_o,
    output logic                 infer_start_o,
    input  logic                 infer_done_i,
    output logic [CNT_W-1:0]     win_events_o,
    output logic                 timeout_err_o,
`ifdef EVT_SCHED_STATS_EN
    output logic [31:0]          win_total_o,
    output logic [31:0]          drop_total_o,
`endif
    output evt_sched_state_t     state_dbg_o
);

    evt_sched_state_t state_q, state_d;

    logic [TS_W-1:0]  win_start_q;
    logic [TS_W-1:0]  delta;
    logic [CNT_W-1:0] evt_cnt_q;
    logic [TW-1:0]    wait_cnt_q;

    logic in_range;
    logic win_expired;
    logic evt_ready;
    logic accept;
    logic close_win;
    logic skip_win;
    logic timeout_hit;
    logic wait_expire;

    logic sweep_start;
    logic sweep_busy;
    logic sweep_done;

    // Modular subtraction makes past timestamps look far in the future, so
    // out-of-order events close the window instead of being accepted.
    assign delta       = evt.evt_timestamp_i - win_start_q;
    assign win_expired = (delta >= TS_W'(WINDOW_LEN));
    assign in_range    = (evt.evt_x_i < COORD_W'(WIDTH)) && (evt.evt_y_i < COORD_W'(HEIGHT));
    assign wait_expire = (wait_cnt_q == TW'(INFER_TIMEOUT - 1));

    assign evt_ready = (state_q == ST_IDLE) || ((state_q == ST_ACCUM) && !win_expired);
    assign accept    = evt.evt_valid_i && evt_ready;

    assign evt.evt_ready_o = evt_ready;
    assign infer_start_o   = (state_q == ST_START);
    assign state_dbg_o     = state_q;

    always_comb begin
        state_d     = state_q;
        close_win   = 1'b0;
        skip_win    = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (sweep_done) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (accept) state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (evt.evt_valid_i && win_expired) begin
                    close_win = 1'b1;
                    if (evt_cnt_q >= CNT_W'(MIN_EVENTS)) begin
                        state_d = ST_START;
                    end else begin
                        skip_win = 1'b1;
                        state_d  = ST_CLEAR;
                    end
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // done on the expiry cycle takes priority over the timeout
                if (infer_done_i) begin
                    state_d = ST_CLEAR;
                end else if (wait_expire) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Launch the sweep on the edge that enters CLEAR (or the first edge out
    // of reset) so the whole CLEAR visit is exactly FRAME_WORDS cycles.
    assign sweep_start = (state_d == ST_CLEAR) && !sweep_busy;

    frame_clear_sweeper #(
        .FRAME_WORDS (FRAME_WORDS),
        .AW          (CAW)
    ) u_sweeper (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (sweep_start),
        .busy_o     (sweep_busy),
        .done_o     (sweep_done),
        .clr_we_o   (clr_we_o),
        .clr_addr_o (clr_addr_o)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= ST_CLEAR;
            win_start_q   <= '0;
            evt_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            win_events_o  <= '0;
            timeout_err_o <= 1'b0;
            acc_we_o      <= 1'b0;
            acc_x_o       <= '0;
            acc_y_o       <= '0;
            acc_pol_o     <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_we_o <= accept && in_range;
            if (accept && in_range) begin
                acc_x_o   <= evt.evt_x_i[AXW-1:0];
                acc_y_o   <= evt.evt_y_i[AYW-1:0];
                acc_pol_o <= evt.evt_polarity_i;
            end
            if (accept && (state_q == ST_IDLE)) begin
                win_start_q <= evt.evt_timestamp_i;
                evt_cnt_q   <= in_range ? CNT_W'(1) : '0;
            end else if (accept && in_range) begin
                evt_cnt_q <= sat_inc(evt_cnt_q);
            end
            if (close_win) win_events_o <= evt_cnt_q;
            if (state_q == ST_START) begin
                wait_cnt_q <= '0;
            end else if (state_q == ST_WAIT) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
            if (timeout_hit) timeout_err_o <= 1'b1;
        end
    end

`ifdef EVT_SCHED_STATS_EN
    logic drop_evt;
    assign drop_evt = accept && !in_range;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            win_total_o  <= '0;
            drop_total_o <= '0;
        end else begin
            win_total_o  <= win_total_o + 32'(close_win);
            drop_total_o <= drop_total_o + 32'(drop_evt) + 32'(skip_win);
        end
    end
`endif

endmodule

// File: tb/tb_evt_window_scheduler.sv
// Directed bench for evt_window_scheduler with small frame/window parameters.
// Stimulus pushes expectations; negedge monitors pop and compare DUT outputs.
module tb_evt_window_scheduler;
    import dlgn_evt_pkg::*;

    localparam int WIDTH         = 4;
    localparam int HEIGHT        = 4;
    localparam int WINDOW_LEN    = 100;
    localparam int MIN_EVENTS    = 2;
    localparam int FRAME_WORDS   = 8;
    localparam int INFER_TIMEOUT = 16;

    logic             clk;
    logic             rst_n;
    logic             acc_we;
    logic [1:0]       acc_x;
    logic [1:0]       acc_y;
    logic             acc_pol;
    logic             clr_we;
    logic [2:0]       clr_addr;
    logic             infer_start;
    logic             infer_done;
    logic [15:0]      win_events;
    logic             timeout_err;
    evt_sched_state_t state_dbg;
`ifdef EVT_SCHED_STATS_EN
    logic [31:0]      win_total;
    logic [31:0]      drop_total;
`endif

    int errors = 0;
    int checks = 0;

    logic [4:0]  exp_acc_q[$];
    logic [15:0] exp_inf_q[$];
    int clr_runs      = 0;
    int exp_clears    = 0;
    int resp_delay    = 0;
    int late_done_cnt = 0;

    evt_window_scheduler_if evt_if ();

    evt_window_scheduler #(
        .WIDTH         (WIDTH),
        .HEIGHT        (HEIGHT),
        .WINDOW_LEN    (WINDOW_LEN),
        .MIN_EVENTS    (MIN_EVENTS),
        .FRAME_WORDS   (FRAME_WORDS),
        .INFER_TIMEOUT (INFER_TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .evt           (evt_if.slave),
        .acc_we_o      (acc_we),
        .acc_x_o       (acc_x),
        .acc_y_o       (acc_y),
        .acc_pol_o     (acc_pol),
        .clr_we_o      (clr_we),
        .clr_addr_o    (clr_addr),
        .infer_start_o (infer_start),
        .infer_done_i  (infer_done),
        .win_events_o  (win_events),
        .timeout_err_o (timeout_err),
`ifdef EVT_SCHED_STATS_EN
        .win_total_o   (win_total),
        .drop_total_o  (drop_total),
`endif
        .state_dbg_o   (state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic expect_acc(input logic [1:0] x, input logic [1:0] y, input logic p);
        exp_acc_q.push_back({x, y, p});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_clr_we"}, 64'(clr_we), 64'd0);
        check({tag, "_ready"}, 64'(evt_if.evt_ready_o), 64'd0);
        check({tag, "_acc_we"}, 64'(acc_we), 64'd0);
        check({tag, "_infer_start"}, 64'(infer_start), 64'd0);
        check({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
        check({tag, "_win_events"}, 64'(win_events), 64'd0);
    endtask

    // driver: present one event and hold it until the handshake completes
    task automatic send_evt(input logic [33:0] ts, input logic [13:0] x, input logic [13:0] y,
                            input logic p, output int waited);
        @(posedge clk);
        #1;
        evt_if.evt_timestamp_i = ts;
        evt_if.evt_x_i         = x;
        evt_if.evt_y_i         = y;
        evt_if.evt_polarity_i  = p;
        evt_if.evt_valid_i     = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            waited++;
            if (evt_if.evt_ready_o) break;
            if (waited >= 100) begin
                checks++;
                errors++;
                $display("FAIL handshake_bound ts=%0d: waited %0d cycles, limit 100", ts, waited);
                break;
            end
        end
        @(posedge clk);
        #1;
        evt_if.evt_valid_i = 1'b0;
    endtask

    task automatic wait_ready(output int latency);
        latency = 0;
        forever begin
            @(negedge clk);
            latency++;
            if (evt_if.evt_ready_o || latency >= 60) break;
        end
    endtask

    // inference responder: done after resp_delay WAIT cycles (0 = never)
    initial begin
        int late_seen;
        late_seen  = 0;
        infer_done = 1'b0;
        forever begin
            @(negedge clk);
            infer_done = 1'b0;
            if (late_done_cnt != late_seen) begin
                infer_done = 1'b1;
                late_seen  = late_done_cnt;
            end else if (infer_start && resp_delay > 0) begin
                repeat (resp_delay) @(negedge clk);
                infer_done = 1'b1;
            end
        end
    end

    // monitor: accumulator writes
    initial begin
        logic [4:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && acc_we) begin
                if (exp_acc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL acc_unexpected: got x=%0d y=%0d p=%0d expected no write", acc_x, acc_y, acc_pol);
                end else begin
                    e = exp_acc_q.pop_front();
                    check("acc_write", 64'({acc_x, acc_y, acc_pol}), 64'(e));
                end
            end
        end
    end

    // monitor: inference start pulses and the window count they report
    initial begin
        logic infer_prev;
        logic [15:0] e;
        infer_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (infer_start) begin
                check("infer_pulse_width", 64'(infer_prev), 64'd0);
                if (exp_inf_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL infer_unexpected: got start with win_events=%0d expected no start", win_events);
                end else begin
                    e = exp_inf_q.pop_front();
                    check("infer_win_events", 64'(win_events), 64'(e));
                end
            end
            infer_prev = infer_start;
        end
    end

    // monitor: clear sweeps must walk 0..FRAME_WORDS-1 contiguously
    initial begin
        int clr_idx;
        clr_idx = 0;
        forever begin
            @(negedge clk);
            if (clr_we) begin
                check("clr_addr", 64'(clr_addr), 64'(clr_idx));
                clr_idx++;
            end else if (clr_idx != 0) begin
                check("clr_len", 64'(clr_idx), 64'(FRAME_WORDS));
                clr_runs++;
                clr_idx = 0;
            end
        end
    end

    // watchdog
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation still running at 200000 time units, limit 200000");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    // stimulus
    initial begin
        int w;
        int lat;
        int seen;
        rst_n                  = 1'b0;
        evt_if.evt_timestamp_i = '0;
        evt_if.evt_x_i         = '0;
        evt_if.evt_y_i         = '0;
        evt_if.evt_polarity_i  = 1'b0;
        evt_if.evt_valid_i     = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_clears++;
        wait_ready(lat);
        check("ready_latency_boot", 64'(lat), 64'd10);

        // window at 10: three in-range events, closed by ts=110 -> inference
        expect_acc(2'd1, 2'd2, 1'b1); send_evt(34'd10, 14'd1, 14'd2, 1'b1, w);
        check("accept_ts10", 64'(w), 64'd1);
        expect_acc(2'd3, 2'd0, 1'b0); send_evt(34'd20, 14'd3, 14'd0, 1'b0, w);
        expect_acc(2'd0, 2'd3, 1'b1); send_evt(34'd50, 14'd0, 14'd3, 1'b1, w);
        resp_delay = 3;
        exp_inf_q.push_back(16'd3);
        exp_clears++;
        expect_acc(2'd2, 2'd2, 1'b0); send_evt(34'd110, 14'd2, 14'd2, 1'b0, w);
        check("stall_ts110", 64'(w), 64'd14);
        check("win_events_w1", 64'(win_events), 64'd3);

        // past timestamp closes the 1-event window at 110; then window at 5 closed by 200
        exp_clears++;
        expect_acc(2'd1, 2'd1, 1'b1); send_evt(34'd5, 14'd1, 14'd1, 1'b1, w);
        check("stall_ts5", 64'(w), 64'd10);
        check("win_events_w2", 64'(win_events), 64'd1);
        exp_clears++;
        expect_acc(2'd0, 2'd0, 1'b0); send_evt(34'd200, 14'd0, 14'd0, 1'b0, w);
        check("stall_ts200", 64'(w), 64'd10);
        check("win_events_w3", 64'(win_events), 64'd1);

        // out-of-range event consumed but not counted; done on the 16th WAIT cycle
        send_evt(34'd210, 14'd7, 14'd1, 1'b1, w);
        check("accept_oor", 64'(w), 64'd1);
        expect_acc(2'd1, 2'd3, 1'b0); send_evt(34'd220, 14'd1, 14'd3, 1'b0, w);
        resp_delay = 16;
        exp_inf_q.push_back(16'd2);
        exp_clears++;
        expect_acc(2'd3, 2'd1, 1'b1); send_evt(34'd400, 14'd3, 14'd1, 1'b1, w);
        check("stall_ts400", 64'(w), 64'd27);
        check("timeout_err_done_at_expiry", 64'(timeout_err), 64'd0);

        // no done at all -> timeout flagged, CLEAR still runs
        expect_acc(2'd2, 2'd0, 1'b1); send_evt(34'd450, 14'd2, 14'd0, 1'b1, w);
        resp_delay = 0;
        exp_inf_q.push_back(16'd2);
        exp_clears++;
        expect_acc(2'd0, 2'd1, 1'b0); send_evt(34'd600, 14'd0, 14'd1, 1'b0, w);
        check("stall_ts600", 64'(w), 64'd27);
        check("timeout_err_set", 64'(timeout_err), 64'd1);

        // timestamp wrap: window at 2^34-50, ts=30 is delta 80, ts=60 is delta 110
        exp_clears++;
        expect_acc(2'd3, 2'd3, 1'b0); send_evt(34'h3_FFFF_FFCE, 14'd3, 14'd3, 1'b0, w);
        check("stall_wrap_start", 64'(w), 64'd10);
        expect_acc(2'd1, 2'd0, 1'b1); send_evt(34'd30, 14'd1, 14'd0, 1'b1, w);
        check("accept_wrap_ts30", 64'(w), 64'd1);
        resp_delay = 2;
        exp_inf_q.push_back(16'd2);
        exp_clears++;
        expect_acc(2'd2, 2'd1, 1'b1); send_evt(34'd60, 14'd2, 14'd1, 1'b1, w);
        check("stall_wrap_ts60", 64'(w), 64'd13);
        check("timeout_err_sticky", 64'(timeout_err), 64'd1);

        // reset while waiting for inference; a late done must be ignored
        expect_acc(2'd3, 2'd3, 1'b1); send_evt(34'd70, 14'd3, 14'd3, 1'b1, w);
        resp_delay = 0;
        exp_inf_q.push_back(16'd2);
        @(posedge clk);
        #1;
        evt_if.evt_timestamp_i = 34'd300;
        evt_if.evt_x_i         = 14'd1;
        evt_if.evt_y_i         = 14'd0;
        evt_if.evt_polarity_i  = 1'b0;
        evt_if.evt_valid_i     = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (infer_start) seen = 1;
        end
        check("reached_wait", 64'(seen), 64'd1);
        repeat (3) @(negedge clk);
        rst_n              = 1'b0;
        evt_if.evt_valid_i = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        late_done_cnt++;
        exp_clears++;
        wait_ready(lat);
        check("ready_latency_rerun", 64'(lat), 64'd10);
        check("late_done_no_err", 64'(timeout_err), 64'd0);

        // fresh window after reset counts from scratch
        expect_acc(2'd0, 2'd1, 1'b0); send_evt(34'd1000, 14'd0, 14'd1, 1'b0, w);
        check("accept_ts1000", 64'(w), 64'd1);
        expect_acc(2'd2, 2'd0, 1'b1); send_evt(34'd1010, 14'd2, 14'd0, 1'b1, w);
        resp_delay = 1;
        exp_inf_q.push_back(16'd2);
        exp_clears++;
        expect_acc(2'd1, 2'd1, 1'b1); send_evt(34'd1200, 14'd1, 14'd1, 1'b1, w);
        check("stall_ts1200", 64'(w), 64'd12);

        repeat (5) @(posedge clk);
        check("acc_queue_drained", 64'(exp_acc_q.size()), 64'd0);
        check("infer_queue_drained", 64'(exp_inf_q.size()), 64'd0);
        check("clear_runs", 64'(clr_runs), 64'(exp_clears));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
